audio_sample_reader: RTL and testbench
======================================

Name: audio_sample_reader

Overview:
- Read-side companion to the DAC sample writer: drains left/right ADC samples from the audio_codec read FIFOs via the read_ready/read_s handshake.
- Mixes each pair to one mono 16-bit sample and buffers it in a small internal FIFO.
- Presents buffered samples downstream on a valid/ready stream for echo, recording or metering logic.
- Sits between audio_codec and any consumer on CLOCK_50.

Parameters:
- DEPTH, 8, capture FIFO depth in samples; power of two, 2..64.
- SHIFT, 1, right arithmetic shift applied to the 17-bit L+R sum; 1 = average, 0 = saturated sum.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- read_ready  in  1  codec: ADC sample pair available.
- readdata_left  in  16  codec left sample, signed two's complement.
- readdata_right  in  16  codec right sample, signed.
- read_s  out  1  codec read strobe.
- out_valid  out  1  mono sample available.
- out_data  out  16  signed mono sample at FIFO head.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset: read_s=0, out_valid=0, out_data=0, overflow=0, FIFO empty, state=S_WAIT_READY. Reset mid-handshake abandons the pair; the codec re-presents it.
- FSM S_WAIT_READY: read_s=0. If read_ready=1, latch readdata_left/right into regs and go to S_POP.
- FSM S_POP: read_s<=1, compute mono, push to FIFO (or drop), go to S_WAIT_ACK.
- FSM S_WAIT_ACK: hold read_s=1 until read_ready=0, then go to S_WAIT_READY with read_s<=0.
- Each pair is consumed exactly once.
- Mono arithmetic: sum = sext17(L) + sext17(R); m = sum >>> SHIFT.
- If SHIFT=0, saturate m to [-32768, 32767].
- Push occurs in S_POP only if the FIFO is not full, including a pop in the same cycle. If full with no simultaneous pop, drop the sample and set overflow=1.
- overflow stays set until ovf_clr=1. If ovf_clr and a drop occur in the same cycle, overflow ends at 1 (set wins).
- FIFO is a circular buffer with rd/wr pointers of log2(DEPTH)+1 bits. Full when the MSBs differ and the rest are equal; empty when the pointers are equal. Pointers wrap naturally.
- out_valid = !empty. out_data is the head entry, registered (no combinational path from read_ready).
- Latency: read_ready sampled high at edge N gives out_valid=1 at edge N+2, if the FIFO was empty.
- Simultaneous push and pop: both take effect; count unchanged.
- The handshake never stalls on a full FIFO. The codec is always drained, so ADC overrun cannot occur.

Optional Feature:
- Macro PEAK_METER_EN.
- When defined: adds output peak[15:0] and input peak_clr.
  - On every push, peak <= max(peak, |m|), with |-32768| saturated to 32767.
  - peak_clr zeroes peak; a push in the same cycle then loads |m|.
  - Reset value 0.
- When undefined: neither port exists and no comparator logic is generated.

Decomposition:
- Package audio_pkg: typedef sample_t (logic signed [15:0]), the reader state enum, constants SAMPLE_MAX=32767 and SAMPLE_MIN=-32768. Shared with the DAC writer.
- One sub-module, sample_fifo (parameter DEPTH, synchronous, push/pop/full/empty/head), is reusable on the playback side.

Test Plan:
- Reset then a single pair L=0x0100, R=0x0300 with out_ready=1 -> read_s pulses through one handshake; out_valid at +2 cycles; out_data=0x0200; overflow=0.
- L=0x8000, R=0x8000 with SHIFT=1 -> out_data=0x8000.
- Same pair with SHIFT=0 -> saturated 0x8000.
- L=0x7FFF, R=0x7FFF with SHIFT=0 -> 0x7FFF.
- out_ready=0 and DEPTH+2 pairs (0..DEPTH+1) -> FIFO holds samples 0..DEPTH-1, overflow=1, every read_s handshake completes. Then ovf_clr -> overflow=0. Draining yields exactly DEPTH samples in order.
- Streaming with out_ready=1 and a pair every 4 cycles over 3*DEPTH samples -> pointer wrap-around, order preserved, no drops, and push/pop in the same cycle keeps count stable.
- Assert reset while in S_WAIT_ACK -> read_s=0 on the next edge, FIFO empty; the next read_ready pair is captured normally.
- With PEAK_METER_EN: samples 0x0100, 0xF000, 0x0200 -> peak=0x1000; peak_clr -> 0; a 0x8000 sample -> peak=0x7FFF.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types, reader FSM states and sample arithmetic helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        S_WAIT_READY = 2'd0,
        S_POP        = 2'd1,
        S_WAIT_ACK   = 2'd2
    } rd_state_t;

    localparam sample_t SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t SAMPLE_MIN = 16'sh8000;

    // Mix a stereo pair to mono: widen, add, arithmetic shift, then clamp.
    // The clamp only bites when shift is 0 (a full-scale sum can need 17 bits).
    function automatic sample_t mix_mono(input sample_t l, input sample_t r, input int shift);
        logic signed [16:0] sum;
        sum = {l[15], l} + {r[15], r};
        sum = sum >>> shift;
        if (sum > 17'sd32767) begin
            return SAMPLE_MAX;
        end else if (sum < -17'sd32768) begin
            return SAMPLE_MIN;
        end else begin
            return sum[15:0];
        end
    endfunction

    // Magnitude with -32768 folded onto +32767 so the result stays in range.
    function automatic sample_t sample_abs(input sample_t m);
        if (m == SAMPLE_MIN) begin
            return SAMPLE_MAX;
        end else if (m < 0) begin
            return -m;
        end else begin
            return m;
        end
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Circular sample buffer with extra-MSB pointers; head is read straight from storage.
// Latency: a push is visible at the head one cycle later when the buffer was empty.
// Backpressure: push ignored when full unless popping the same cycle; pop ignored when empty.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic    CLOCK_50,
    input  logic    reset,
    input  logic    i_push,
    input  sample_t i_push_dat,
    input  logic    i_pop,
    output logic    o_full,
    output logic    o_empty,
    output sample_t o_head
);
    localparam int AW = $clog2(DEPTH);

    sample_t       r_mem [DEPTH];
    logic [AW:0]   r_wr;
    logic [AW:0]   r_rd;
    logic          w_full;
    logic          w_empty;
    logic          w_do_pop;
    logic          w_do_push;

    assign w_empty   = (r_wr == r_rd);
    assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    // When full, a same-cycle pop frees the very slot the write lands in.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_head  = w_empty ? sample_t'(0) : r_mem[r_rd[AW-1:0]];

    // Pointer advance and storage write; pointers wrap through the extra MSB.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr[AW-1:0]] <= i_push_dat;
                r_wr                <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_sample_reader.sv
// Drains codec ADC pairs, mixes to mono, buffers in sample_fifo, streams out valid/ready.
// Latency: read_ready sampled at edge N -> out_valid seen after edge N+1 (sampled high at N+2).
// Backpressure: codec is never stalled; a full buffer drops the sample and sets sticky overflow.
// Optional PEAK_METER_EN adds peak/peak_clr: running max of |mono| over pushed samples.
module audio_sample_reader
    import audio_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SHIFT = 1
)
(
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        read_ready,
    input  logic [15:0] readdata_left,
    input  logic [15:0] readdata_right,
    output logic        read_s,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        overflow,
    input  logic        ovf_clr
`ifdef PEAK_METER_EN
    ,
    output logic [15:0] peak,
    input  logic        peak_clr
`endif
);
    rd_state_t r_state;
    logic      r_read_s;
    sample_t   r_left;
    sample_t   r_right;
    logic      r_overflow;

    sample_t   w_mono;
    logic      w_push_req;
    logic      w_pop;
    logic      w_full;
    logic      w_empty;
    logic      w_drop;
    sample_t   w_head;

    assign w_mono     = mix_mono(r_left, r_right, SHIFT);
    assign w_push_req = (r_state == S_POP);
    assign w_pop      = !w_empty && out_ready;
    assign w_drop     = w_push_req && w_full && !w_pop;

    assign read_s    = r_read_s;
    assign out_valid = !w_empty;
    assign out_data  = w_head;
    assign overflow  = r_overflow;

    // Codec handshake: capture pair, strobe read_s, wait for read_ready to fall.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= S_WAIT_READY;
            r_read_s <= 1'b0;
            r_left   <= '0;
            r_right  <= '0;
        end else begin
            case (r_state)
                S_WAIT_READY: begin
                    r_read_s <= 1'b0;
                    if (read_ready) begin
                        r_left  <= readdata_left;
                        r_right <= readdata_right;
                        r_state <= S_POP;
                    end
                end
                S_POP: begin
                    r_read_s <= 1'b1;
                    r_state  <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!read_ready) begin
                        r_read_s <= 1'b0;
                        r_state  <= S_WAIT_READY;
                    end
                end
                default: begin
                    r_read_s <= 1'b0;
                    r_state  <= S_WAIT_READY;
                end
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .i_push     (w_push_req),
        .i_push_dat (w_mono),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head)
    );

`ifdef PEAK_METER_EN
    sample_t r_peak;
    sample_t w_abs;
    logic    w_push_ok;

    assign w_abs     = sample_abs(w_mono);
    assign w_push_ok = w_push_req && !w_drop;
    assign peak      = r_peak;

    // Running peak of accepted samples; a clear coinciding with a push reloads from it.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_peak <= '0;
        end else if (w_push_ok) begin
            r_peak <= (peak_clr || (w_abs > r_peak)) ? w_abs : r_peak;
        end else if (peak_clr) begin
            r_peak <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_audio_sample_reader.sv
// Directed bench: an averaging instance (SHIFT=1) and a saturating instance (SHIFT=0) on shared stimulus.
// Latency: n/a.
// Backpressure: out_ready driven per test sequence.
module tb_audio_sample_reader;

    localparam int DEPTH = 8;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        read_ready;
    logic [15:0] readdata_left;
    logic [15:0] readdata_right;
    logic        out_ready;
    logic        ovf_clr;

    logic        read_s_a, out_valid_a, overflow_a;
    logic [15:0] out_data_a;
    logic        read_s_s, out_valid_s, overflow_s;
    logic [15:0] out_data_s;
`ifdef PEAK_METER_EN
    logic        peak_clr;
    logic [15:0] peak_a, peak_s;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit exp_ovf;
    logic [15:0] q_avg[$];
    logic [15:0] q_sat[$];

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] ea;
        logic [15:0] es;
    } vec_t;
    vec_t vecs[8];

    always #5 CLOCK_50 = ~CLOCK_50;

    audio_sample_reader #(.DEPTH(DEPTH), .SHIFT(1)) u_avg (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .read_ready     (read_ready),
        .readdata_left  (readdata_left),
        .readdata_right (readdata_right),
        .read_s         (read_s_a),
        .out_valid      (out_valid_a),
        .out_data       (out_data_a),
        .out_ready      (out_ready),
        .overflow       (overflow_a),
        .ovf_clr        (ovf_clr)
`ifdef PEAK_METER_EN
        ,
        .peak           (peak_a),
        .peak_clr       (peak_clr)
`endif
    );

    audio_sample_reader #(.DEPTH(DEPTH), .SHIFT(0)) u_sat (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .read_ready     (read_ready),
        .readdata_left  (readdata_left),
        .readdata_right (readdata_right),
        .read_s         (read_s_s),
        .out_valid      (out_valid_s),
        .out_data       (out_data_s),
        .out_ready      (out_ready),
        .overflow       (overflow_s),
        .ovf_clr        (ovf_clr)
`ifdef PEAK_METER_EN
        ,
        .peak           (peak_s),
        .peak_clr       (peak_clr)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        read_ready = 1'b0;
        out_ready  = 1'b0;
        ovf_clr    = 1'b0;
`ifdef PEAK_METER_EN
        peak_clr   = 1'b0;
`endif
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        q_avg.delete();
        q_sat.delete();
        exp_ovf = 1'b0;
    endtask

    // One codec handshake; optionally pops the head in the cycle the pair is being pushed.
    task automatic send_pair(input logic [15:0] l, input logic [15:0] r,
                             input logic [15:0] ea, input logic [15:0] es, input bit pop_now);
        readdata_left  = l;
        readdata_right = r;
        read_ready     = 1'b1;
        @(negedge CLOCK_50);
        if (pop_now) begin
            check("pop_vld", {31'd0, out_valid_a}, 32'd1);
            if (q_avg.size() > 0) begin
                check("pop_avg", {16'd0, out_data_a}, {16'd0, q_avg[0]});
                check("pop_sat", {16'd0, out_data_s}, {16'd0, q_sat[0]});
                void'(q_avg.pop_front());
                void'(q_sat.pop_front());
            end
            out_ready = 1'b1;
        end
        if (pop_now || q_avg.size() < DEPTH) begin
            q_avg.push_back(ea);
            q_sat.push_back(es);
        end else begin
            exp_ovf = 1'b1;
        end
        @(negedge CLOCK_50);
        out_ready = 1'b0;
        for (int n = 0; n < 8 && !read_s_a; n++) @(negedge CLOCK_50);
        check("hs_ack", {31'd0, read_s_a}, 32'd1);
        read_ready = 1'b0;
        for (int n = 0; n < 8 && read_s_a; n++) @(negedge CLOCK_50);
        check("hs_rel", {31'd0, read_s_a}, 32'd0);
        check("ovf_a", {31'd0, overflow_a}, {31'd0, exp_ovf});
        check("ovf_s", {31'd0, overflow_s}, {31'd0, exp_ovf});
    endtask

    task automatic drain_all();
        while (q_avg.size() > 0) begin
            check("drn_vld", {31'd0, out_valid_a}, 32'd1);
            check("drn_avg", {16'd0, out_data_a}, {16'd0, q_avg[0]});
            check("drn_sat", {16'd0, out_data_s}, {16'd0, q_sat[0]});
            out_ready = 1'b1;
            @(negedge CLOCK_50);
            out_ready = 1'b0;
            void'(q_avg.pop_front());
            void'(q_sat.pop_front());
        end
        check("drn_empty_a", {31'd0, out_valid_a}, 32'd0);
        check("drn_empty_s", {31'd0, out_valid_s}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0100, 16'h0300, 16'h0200, 16'h0400};
        vecs[1] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[3] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000};
        vecs[4] = '{16'hFFFF, 16'hFFFE, 16'hFFFE, 16'hFFFD};
        vecs[5] = '{16'h4000, 16'h4000, 16'h4000, 16'h7FFF};
        vecs[6] = '{16'hC000, 16'hBFFF, 16'hBFFF, 16'h8000};
        vecs[7] = '{16'h1234, 16'h0001, 16'h091A, 16'h1235};

        readdata_left  = '0;
        readdata_right = '0;
        do_reset();

        // Reset state
        check("rst_read_s", {31'd0, read_s_a}, 32'd0);
        check("rst_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst_data", {16'd0, out_data_a}, 32'd0);
        check("rst_ovf", {31'd0, overflow_a}, 32'd0);
        check("rst_valid_s", {31'd0, out_valid_s}, 32'd0);

        // First-pair latency with out_ready held high
        out_ready      = 1'b1;
        readdata_left  = 16'h0100;
        readdata_right = 16'h0300;
        read_ready     = 1'b1;
        @(negedge CLOCK_50);
        check("lat_n1_valid", {31'd0, out_valid_a}, 32'd0);
        check("lat_n1_read_s", {31'd0, read_s_a}, 32'd0);
        @(negedge CLOCK_50);
        check("lat_n2_valid", {31'd0, out_valid_a}, 32'd1);
        check("lat_n2_avg", {16'd0, out_data_a}, 32'h0200);
        check("lat_n2_sat", {16'd0, out_data_s}, 32'h0400);
        check("lat_n2_read_s", {31'd0, read_s_a}, 32'd1);
        read_ready = 1'b0;
        @(negedge CLOCK_50);
        check("lat_rel_read_s", {31'd0, read_s_a}, 32'd0);
        check("lat_popped", {31'd0, out_valid_a}, 32'd0);
        check("lat_ovf", {31'd0, overflow_a}, 32'd0);
        out_ready = 1'b0;

        // Mixing table
        for (int i = 0; i < 8; i++) begin
            send_pair(vecs[i].l, vecs[i].r, vecs[i].ea, vecs[i].es, 1'b0);
            drain_all();
        end

        // Overflow: DEPTH+2 pairs with the consumer stalled
        for (int i = 0; i < DEPTH + 2; i++) begin
            send_pair(16'(i), 16'(i), 16'(i), 16'(2 * i), 1'b0);
        end
        check("ovf_set", {31'd0, overflow_a}, 32'd1);
        @(negedge CLOCK_50);
        check("ovf_sticky", {31'd0, overflow_a}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge CLOCK_50);
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_clr_a", {31'd0, overflow_a}, 32'd0);
        check("ovf_clr_s", {31'd0, overflow_s}, 32'd0);
        drain_all();

        // Full buffer with push+pop in the same cycle, wrapping pointers several times
        for (int i = 0; i < DEPTH; i++) begin
            send_pair(16'(64 + i), 16'(64 + i), 16'(64 + i), 16'(128 + 2 * i), 1'b0);
        end
        for (int i = DEPTH; i < 4 * DEPTH; i++) begin
            send_pair(16'(64 + i), 16'(64 + i), 16'(64 + i), 16'(128 + 2 * i), 1'b1);
        end
        check("stream_no_ovf", {31'd0, overflow_a}, 32'd0);
        drain_all();

        // Reset while waiting for the codec to drop read_ready
        readdata_left  = 16'h1111;
        readdata_right = 16'h1111;
        read_ready     = 1'b1;
        for (int n = 0; n < 8 && !read_s_a; n++) @(negedge CLOCK_50);
        check("mid_in_ack", {31'd0, read_s_a}, 32'd1);
        check("mid_pushed", {31'd0, out_valid_a}, 32'd1);
        reset      = 1'b1;
        read_ready = 1'b0;
        @(negedge CLOCK_50);
        check("mid_read_s", {31'd0, read_s_a}, 32'd0);
        check("mid_empty", {31'd0, out_valid_a}, 32'd0);
        reset = 1'b0;
        q_avg.delete();
        q_sat.delete();
        exp_ovf = 1'b0;
        @(negedge CLOCK_50);
        send_pair(16'h0010, 16'h0030, 16'h0020, 16'h0040, 1'b0);
        drain_all();

`ifdef PEAK_METER_EN
        do_reset();
        check("pk_rst", {16'd0, peak_a}, 32'd0);
        send_pair(16'h0100, 16'h0100, 16'h0100, 16'h0200, 1'b0);
        send_pair(16'hF000, 16'hF000, 16'hF000, 16'hE000, 1'b0);
        send_pair(16'h0200, 16'h0200, 16'h0200, 16'h0400, 1'b0);
        check("pk_a", {16'd0, peak_a}, 32'h1000);
        check("pk_s", {16'd0, peak_s}, 32'h2000);
        peak_clr = 1'b1;
        @(negedge CLOCK_50);
        peak_clr = 1'b0;
        check("pk_clr_a", {16'd0, peak_a}, 32'd0);
        check("pk_clr_s", {16'd0, peak_s}, 32'd0);
        send_pair(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0);
        check("pk_min_a", {16'd0, peak_a}, 32'h7FFF);
        check("pk_min_s", {16'd0, peak_s}, 32'h7FFF);
        drain_all();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
